// File: rtl/sram_ctrl.sv
// Request-side controller for a 256K x 16 asynchronous SRAM: one-entry command
// register, read/write turnaround FSM, registered pad requests and in-order read return.
module sram_ctrl #(
    parameter int TURNAROUND_CYCLES = 1,
    parameter int RD_LATENCY        = 3
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [17:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    input  logic [1:0]  cmd_be,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        idle,
    output logic        sram_ce_to_pad_,
    output logic        sram_we_to_pad_f_,
    output logic        sram_oe_to_pad_f_,
    output logic        sram_lb_to_pad_,
    output logic        sram_ub_to_pad_,
    output logic [17:0] sram_addr_to_pad,
    output logic        sram_data_pad_ena,
    output logic [15:0] sram_data_to_pad,
    input  logic        sram_data_from_pad_vld,
    input  logic [15:0] sram_data_from_pad
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_TURN} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_RD, DIR_WR} dir_t;

    localparam int                 BLANK_W    = $clog2(RD_LATENCY + 2);
    localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(RD_LATENCY + 1);

    state_t             state, state_nxt;
    dir_t               dir_last, dir_nxt;
    logic [1:0]         turn_cnt, turn_cnt_nxt;
    logic [2:0]         outstanding, outstanding_nxt;
    logic [BLANK_W-1:0] blank_cnt;
    logic               accept, issue, opposite, stray;
    logic               vld_p0, vld_p0_nxt, wr_p0, wr_nxt;
    logic [17:0]        addr_p0;
    logic [15:0]        wdata_p0;
    logic [1:0]         be_p0;
    logic               ready_nxt, idle_nxt;
    logic               ce_nxt, we_nxt, oe_nxt, lb_nxt, ub_nxt, ena_nxt;
    logic [17:0]        addr_nxt;
    logic [15:0]        data_nxt;

    assign accept      = cmd_valid && cmd_ready;
    assign vld_p0_nxt  = accept || (vld_p0 && !issue);
    assign wr_nxt      = accept ? cmd_wr : wr_p0;
    assign stray       = sram_data_from_pad_vld && (outstanding == 3'd0) && (blank_cnt == '0);
    assign rsp_valid   = sram_data_from_pad_vld && (outstanding != 3'd0);
    assign rsp_rdata   = sram_data_from_pad;
    assign outstanding_nxt = outstanding + {2'b0, state == S_RD} - {2'b0, rsp_valid};

    // State register and control state
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state       <= S_IDLE;
            dir_last    <= DIR_NONE;
            turn_cnt    <= 2'd0;
            vld_p0      <= 1'b0;
            outstanding <= 3'd0;
            blank_cnt   <= BLANK_INIT;
            cmd_ready   <= 1'b0;
            idle        <= 1'b1;
            rsp_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            dir_last    <= dir_nxt;
            turn_cnt    <= turn_cnt_nxt;
            vld_p0      <= vld_p0_nxt;
            outstanding <= outstanding_nxt;
            if (blank_cnt != '0)
                blank_cnt <= blank_cnt - BLANK_W'(1);
            cmd_ready   <= ready_nxt;
            idle        <= idle_nxt;
            if (stray)
                rsp_err <= 1'b1;
        end
    end

    // Command register (p0): payload only, validity lives in vld_p0
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_p0    <= cmd_wr;
            addr_p0  <= cmd_addr;
            wdata_p0 <= cmd_wdata;
            be_p0    <= cmd_be;
        end
    end

    always_comb begin
        state_nxt    = S_IDLE;
        turn_cnt_nxt = turn_cnt;
        issue        = 1'b0;
        opposite     = vld_p0 && ((wr_p0 && dir_last == DIR_RD) || (!wr_p0 && dir_last == DIR_WR));
        if (state == S_TURN) begin
            if (turn_cnt == 2'd0) begin
                state_nxt = wr_p0 ? S_WR : S_RD;
                issue     = 1'b1;
            end else begin
                state_nxt    = S_TURN;
                turn_cnt_nxt = turn_cnt - 2'd1;
            end
        end else if (vld_p0) begin
            if (opposite) begin
                state_nxt    = S_TURN;
                turn_cnt_nxt = 2'(TURNAROUND_CYCLES - 1);
            end else begin
                state_nxt = wr_p0 ? S_WR : S_RD;
                issue     = 1'b1;
            end
        end
    end

    // Ready is registered, so it predicts whether next cycle's held command will issue
    always_comb begin
        dir_nxt   = (state_nxt == S_RD) ? DIR_RD : (state_nxt == S_WR) ? DIR_WR : DIR_NONE;
        ready_nxt = (state_nxt != S_TURN) &&
                    (!vld_p0_nxt || !((dir_nxt == DIR_RD && wr_nxt) || (dir_nxt == DIR_WR && !wr_nxt)));
        idle_nxt  = (state_nxt == S_IDLE) && !vld_p0_nxt && (outstanding_nxt == 3'd0);
        ce_nxt    = 1'b1;
        we_nxt    = 1'b1;
        oe_nxt    = 1'b1;
        lb_nxt    = 1'b1;
        ub_nxt    = 1'b1;
        ena_nxt   = 1'b0;
        addr_nxt  = sram_addr_to_pad;
        data_nxt  = sram_data_to_pad;
        case (state_nxt)
            S_RD: begin
                ce_nxt   = 1'b0;
                oe_nxt   = 1'b0;
                lb_nxt   = 1'b0;
                ub_nxt   = 1'b0;
                addr_nxt = addr_p0;
            end
            S_WR: begin
                ce_nxt   = (be_p0 == 2'b00);
                we_nxt   = 1'b0;
                lb_nxt   = ~be_p0[0];
                ub_nxt   = ~be_p0[1];
                ena_nxt  = 1'b1;
                addr_nxt = addr_p0;
                data_nxt = wdata_p0;
            end
            default: ;
        endcase
    end

    // Pad request stage
    always_ff @(posedge clk) begin
        if (!reset_) begin
            sram_ce_to_pad_   <= 1'b1;
            sram_we_to_pad_f_ <= 1'b1;
            sram_oe_to_pad_f_ <= 1'b1;
            sram_lb_to_pad_   <= 1'b1;
            sram_ub_to_pad_   <= 1'b1;
            sram_addr_to_pad  <= 18'd0;
            sram_data_pad_ena <= 1'b0;
            sram_data_to_pad  <= 16'd0;
        end else begin
            sram_ce_to_pad_   <= ce_nxt;
            sram_we_to_pad_f_ <= we_nxt;
            sram_oe_to_pad_f_ <= oe_nxt;
            sram_lb_to_pad_   <= lb_nxt;
            sram_ub_to_pad_   <= ub_nxt;
            sram_addr_to_pad  <= addr_nxt;
            sram_data_pad_ena <= ena_nxt;
            sram_data_to_pad  <= data_nxt;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a small pad-stage model returning reads after 3 cycles.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [17:0] cmd_addr = 18'd0;
    logic [15:0] cmd_wdata = 16'd0;
    logic [1:0]  cmd_be = 2'b00;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        idle;
    logic        sram_ce_to_pad_, sram_we_to_pad_f_, sram_oe_to_pad_f_;
    logic        sram_lb_to_pad_, sram_ub_to_pad_;
    logic [17:0] sram_addr_to_pad;
    logic        sram_data_pad_ena;
    logic [15:0] sram_data_to_pad;
    logic        sram_data_from_pad_vld;
    logic [15:0] sram_data_from_pad;

    logic        rd_s1 = 1'b0, rd_s2 = 1'b0, model_vld = 1'b0, inj = 1'b0, data_mode = 1'b0;
    logic [17:0] a_s1 = 18'd0, a_s2 = 18'd0;
    logic [15:0] model_data = 16'd0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pulses;
    int          waited;

    sram_ctrl #(.TURNAROUND_CYCLES(1), .RD_LATENCY(3)) dut (
        .clk(clk), .reset_(reset_),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .idle(idle),
        .sram_ce_to_pad_(sram_ce_to_pad_), .sram_we_to_pad_f_(sram_we_to_pad_f_),
        .sram_oe_to_pad_f_(sram_oe_to_pad_f_), .sram_lb_to_pad_(sram_lb_to_pad_),
        .sram_ub_to_pad_(sram_ub_to_pad_), .sram_addr_to_pad(sram_addr_to_pad),
        .sram_data_pad_ena(sram_data_pad_ena), .sram_data_to_pad(sram_data_to_pad),
        .sram_data_from_pad_vld(sram_data_from_pad_vld), .sram_data_from_pad(sram_data_from_pad)
    );

    always #5 clk = ~clk;

    // Pad stage: a read request cycle M yields a capture strobe in cycle M+3
    always @(posedge clk) begin
        rd_s1      <= !sram_ce_to_pad_ && !sram_oe_to_pad_f_;
        a_s1       <= sram_addr_to_pad;
        rd_s2      <= rd_s1;
        a_s2       <= a_s1;
        model_vld  <= rd_s2;
        model_data <= data_mode ? a_s2[15:0] : 16'hA5C3;
    end

    assign sram_data_from_pad_vld = model_vld | inj;
    assign sram_data_from_pad     = model_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pad_idle(input string tag);
        chk({tag, "_ce"}, 32'(sram_ce_to_pad_), 32'd1);
        chk({tag, "_we"}, 32'(sram_we_to_pad_f_), 32'd1);
        chk({tag, "_oe"}, 32'(sram_oe_to_pad_f_), 32'd1);
        chk({tag, "_ena"}, 32'(sram_data_pad_ena), 32'd0);
    endtask

    initial begin
        // Reset held for 3 cycles with a pending command
        cmd_valid = 1'b1;
        repeat (3) tick;
        chk_pad_idle("rst");
        chk("rst_lb", 32'(sram_lb_to_pad_), 32'd1);
        chk("rst_ub", 32'(sram_ub_to_pad_), 32'd1);
        chk("rst_addr", 32'(sram_addr_to_pad), 32'd0);
        chk("rst_data", 32'(sram_data_to_pad), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        reset_ = 1'b1;
        tick;
        chk("rel_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;
        tick;
        chk("rel_no_accept_ce", 32'(sram_ce_to_pad_), 32'd1);
        chk("rel_idle", 32'(idle), 32'd1);

        // Write burst to 0x10..0x13
        cmd_wr = 1'b1;
        cmd_be = 2'b11;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_addr  = 18'(32'h10 + i);
            cmd_wdata = 16'(32'hB000 + i);
            tick;
            chk("wb_ready", 32'(cmd_ready), 32'd1);
            if (i > 0) begin
                chk("wb_ce", 32'(sram_ce_to_pad_), 32'd0);
                chk("wb_ena", 32'(sram_data_pad_ena), 32'd1);
                chk("wb_addr", 32'(sram_addr_to_pad), 32'h10 + i - 1);
                chk("wb_data", 32'(sram_data_to_pad), 32'hB000 + i - 1);
            end
        end
        cmd_valid = 1'b0;
        tick;
        chk("wb_last_ce", 32'(sram_ce_to_pad_), 32'd0);
        chk("wb_last_we", 32'(sram_we_to_pad_f_), 32'd0);
        chk("wb_last_addr", 32'(sram_addr_to_pad), 32'h13);
        chk("wb_last_data", 32'(sram_data_to_pad), 32'hB003);
        chk("wb_last_ready", 32'(cmd_ready), 32'd1);
        tick;
        chk("wb_done_ce", 32'(sram_ce_to_pad_), 32'd1);
        chk("wb_done_idle", 32'(idle), 32'd1);

        // Write then read of the top address, one turnaround cycle
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 18'h3FFFF;
        cmd_wdata = 16'h1234;
        tick;
        chk("wr_accept_ready", 32'(cmd_ready), 32'd1);
        cmd_wr = 1'b0;
        tick;
        chk("wr_ce", 32'(sram_ce_to_pad_), 32'd0);
        chk("wr_addr", 32'(sram_addr_to_pad), 32'h3FFFF);
        chk("wr_ready_blocked", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        tick;
        chk_pad_idle("turn");
        chk("turn_addr_hold", 32'(sram_addr_to_pad), 32'h3FFFF);
        chk("turn_data_hold", 32'(sram_data_to_pad), 32'h1234);
        chk("turn_ready", 32'(cmd_ready), 32'd0);
        tick;
        chk("rd_ce", 32'(sram_ce_to_pad_), 32'd0);
        chk("rd_oe", 32'(sram_oe_to_pad_f_), 32'd0);
        chk("rd_we", 32'(sram_we_to_pad_f_), 32'd1);
        chk("rd_lbub", 32'({sram_lb_to_pad_, sram_ub_to_pad_}), 32'd0);
        chk("rd_ena", 32'(sram_data_pad_ena), 32'd0);
        chk("rd_addr", 32'(sram_addr_to_pad), 32'h3FFFF);
        tick;
        chk("rd_lat1", 32'(rsp_valid), 32'd0);
        tick;
        chk("rd_lat2", 32'(rsp_valid), 32'd0);
        tick;
        chk("rd_lat3_valid", 32'(rsp_valid), 32'd1);
        chk("rd_lat3_data", 32'(rsp_rdata), 32'hA5C3);
        chk("rd_lat3_idle", 32'(idle), 32'd0);
        tick;
        chk("rd_after_valid", 32'(rsp_valid), 32'd0);
        chk("rd_after_idle", 32'(idle), 32'd1);
        chk("rd_after_err", 32'(rsp_err), 32'd0);

        // Byte enables: low byte only, then none
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 18'd5;
        cmd_wdata = 16'h00FF;
        cmd_be    = 2'b01;
        tick;
        cmd_valid = 1'b0;
        tick;
        chk("be01_ce", 32'(sram_ce_to_pad_), 32'd0);
        chk("be01_lb", 32'(sram_lb_to_pad_), 32'd0);
        chk("be01_ub", 32'(sram_ub_to_pad_), 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = 18'd6;
        cmd_be    = 2'b00;
        tick;
        cmd_valid = 1'b0;
        tick;
        chk("be00_ce", 32'(sram_ce_to_pad_), 32'd1);
        chk("be00_lbub", 32'({sram_lb_to_pad_, sram_ub_to_pad_}), 32'd3);
        chk("be00_addr", 32'(sram_addr_to_pad), 32'd6);
        tick;
        tick;

        // Read burst of 5, model returns the address as data
        data_mode = 1'b1;
        cmd_wr    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_addr  = 18'(i);
            tick;
            chk("rb_ready", 32'(cmd_ready), 32'd1);
        end
        cmd_valid = 1'b0;
        pulses = 0;
        waited = 0;
        while (pulses < 5 && waited < 30) begin
            chk("rb_idle_busy", 32'(idle), 32'd0);
            if (rsp_valid) begin
                chk("rb_data", 32'(rsp_rdata), 32'(pulses));
                pulses++;
            end
            if (pulses < 5) begin
                tick;
                waited++;
            end
        end
        chk("rb_count", 32'(pulses), 32'd5);
        tick;
        chk("rb_idle_after", 32'(idle), 32'd1);
        chk("rb_err", 32'(rsp_err), 32'd0);

        // Stray capture strobes: dropped while blanking, flagged afterwards
        reset_ = 1'b0;
        tick;
        tick;
        reset_ = 1'b1;
        tick;
        inj = 1'b1;
        #1;
        chk("blank_rsp_valid", 32'(rsp_valid), 32'd0);
        tick;
        inj = 1'b0;
        chk("blank_err", 32'(rsp_err), 32'd0);
        repeat (8) tick;
        inj = 1'b1;
        #1;
        chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
        tick;
        inj = 1'b0;
        chk("stray_err_set", 32'(rsp_err), 32'd1);
        repeat (3) tick;
        chk("stray_err_sticky", 32'(rsp_err), 32'd1);
        reset_ = 1'b0;
        tick;
        chk("stray_err_cleared", 32'(rsp_err), 32'd0);
        chk("final_idle", 32'(idle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
